bnn_neuron_stream: RTL and testbench

- Next-generation binary neuron for the fully-connected BNN layers.
- Consumes one input/weight vector of arbitrary length (up to MAX_INPUTS) as a stream of PW-bit beats with a lane mask and a last flag.
- Computes XNOR-popcount per beat and accumulates across beats. At vector end it emits the total match count and the thresholded activation bit.
- Fully pipelined with valid/ready handshakes: one beat per cycle, back-to-back vectors, global stall on output backpressure.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/bnn_neuron_stream_if.sv | 34 +++
 rtl/bnn_popcount.sv | 19 +
 rtl/bnn_neuron_stream.sv | 133 +++++++++++++
 tb/tb_bnn_neuron_stream.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-neuron stream datapath.
//   cnt_width(n) : bits needed to hold a count in the range 0..n
//   stage_ctl_t  : per-stage control record (last, valid). Each pipeline
//                  stage wraps it with its own payload (mask or popcount,
//                  plus the threshold).
package bnn_pkg;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic last;
        logic valid;
    } stage_ctl_t;

endpackage

// File: rtl/bnn_neuron_stream_if.sv
// Beat-in / result-out handshake bundle for bnn_neuron_stream.
//   in_valid/in_ready            beat handshake
//   in_w, in_x, in_keep          weight, activation and lane mask (PW bits each)
//   in_last, in_threshold        end-of-vector flag and its threshold
//   out_valid/out_ready          result handshake
//   out_count, out_act           match count and thresholded activation
// master = producer of beats and consumer of results; slave = the neuron.
interface bnn_neuron_stream_if #(
    parameter int PW             = 8,
    parameter int CNT_W          = 10,
    parameter int THRESHOLD_BITS = CNT_W
);
    logic                      in_valid;
    logic                      in_ready;
    logic [PW-1:0]             in_w;
    logic [PW-1:0]             in_x;
    logic [PW-1:0]             in_keep;
    logic                      in_last;
    logic [THRESHOLD_BITS-1:0] in_threshold;
    logic                      out_valid;
    logic                      out_ready;
    logic [CNT_W-1:0]          out_count;
    logic                      out_act;

    modport master (
        output in_valid, in_w, in_x, in_keep, in_last, in_threshold, out_ready,
        input  in_ready, out_valid, out_count, out_act
    );

    modport slave (
        input  in_valid, in_w, in_x, in_keep, in_last, in_threshold, out_ready,
        output in_ready, out_valid, out_count, out_act
    );
endinterface

// File: rtl/bnn_popcount.sv
// Combinational population count.
//   in  [W-1:0]              bits to count
//   out [$clog2(W+1)-1:0]    number of ones in "in"
module bnn_popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]             in,
    output logic [$clog2(W+1)-1:0]   out
);
    localparam int OW = $clog2(W + 1);

    // Written as a reduction loop; synthesis balances it into an adder tree.
    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < W; i++) begin
            out = out + OW'(in[i]);
        end
    end
endmodule

// File: rtl/bnn_neuron_stream.sv
// Streaming binary neuron: XNOR-popcount over a vector delivered as PW-bit
// beats, accumulated across beats, thresholded at the last beat.
//   clk, rst     clock and synchronous active-high reset
//   bus (slave)  beat input handshake and result output handshake
// Pipeline: S1 registers the masked XNOR, S2 the beat popcount, S3 the
// running sum and the output result. A single global stall
// (out_valid && !out_ready) freezes all three stages.
module bnn_neuron_stream
    import bnn_pkg::*;
#(
    parameter int PW             = 8,
    parameter int MAX_INPUTS     = 784,
    parameter int THRESHOLD_BITS = cnt_width(MAX_INPUTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    bnn_neuron_stream_if.slave   bus
);
    localparam int CNT_W = cnt_width(MAX_INPUTS);
    localparam int PC_W  = cnt_width(PW);
    localparam int CMP_W = (CNT_W > THRESHOLD_BITS) ? CNT_W : THRESHOLD_BITS;
    localparam logic [CNT_W:0] MAX_SUM = (CNT_W + 1)'(MAX_INPUTS);

    typedef struct packed {
        logic [PW-1:0]             mask;
        logic [THRESHOLD_BITS-1:0] threshold;
        stage_ctl_t                ctl;
    } s1_t;

    typedef struct packed {
        logic [PC_W-1:0]           pc;
        logic [THRESHOLD_BITS-1:0] threshold;
        stage_ctl_t                ctl;
    } s2_t;

    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_act_q, out_act_d;

    logic             stall;
    logic             accept;
    logic [PC_W-1:0]  pc_w;
    logic [CNT_W:0]   sum_raw;
    logic [CNT_W-1:0] sum;

    assign stall         = out_valid_q && !bus.out_ready;
    assign accept        = bus.in_valid && !stall;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_act   = out_act_q;

    // S1: masked XNOR. The threshold only matters on the last beat, so it is
    // captured there and otherwise left alone.
    always_comb begin
        s1_d = s1_q;
        if (!stall) begin
            s1_d.ctl.valid = accept;
            if (accept) begin
                s1_d.mask     = (bus.in_w ~^ bus.in_x) & bus.in_keep;
                s1_d.ctl.last = bus.in_last;
                if (bus.in_last) begin
                    s1_d.threshold = bus.in_threshold;
                end
            end
        end
    end

    bnn_popcount #(.W(PW)) u_popcount (
        .in  (s1_q.mask),
        .out (pc_w)
    );

    // S2: beat popcount plus carried control.
    always_comb begin
        s2_d = s2_q;
        if (!stall) begin
            s2_d.pc        = pc_w;
            s2_d.threshold = s1_q.threshold;
            s2_d.ctl       = s1_q.ctl;
        end
    end

    // S3: saturating accumulate; the extra sum bit catches overflow past
    // MAX_INPUTS before the clamp.
    always_comb begin
        sum_raw = {1'b0, acc_q} + (CNT_W + 1)'(s2_q.pc);
        sum     = (sum_raw > MAX_SUM) ? MAX_SUM[CNT_W-1:0] : sum_raw[CNT_W-1:0];
    end

    // Not stalled means the held result (if any) is being taken, so
    // out_valid follows whether a new result completes this cycle.
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_act_d   = out_act_q;
        if (!stall) begin
            out_valid_d = 1'b0;
            if (s2_q.ctl.valid) begin
                if (s2_q.ctl.last) begin
                    out_count_d = sum;
                    out_act_d   = (CMP_W'(sum) >= CMP_W'(s2_q.threshold));
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_act_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_act_q   <= out_act_d;
        end
    end
endmodule

// File: tb/tb_bnn_neuron_stream.sv
// Directed bench for bnn_neuron_stream: a MAX_INPUTS=32 instance for the main
// sequence and a MAX_INPUTS=16 instance for saturation. Expected results are
// queued when a vector is driven and compared when the DUT hands them over.
module tb_bnn_neuron_stream;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        bit act;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    bnn_neuron_stream_if #(.PW(8), .CNT_W(6), .THRESHOLD_BITS(6)) b32 ();
    bnn_neuron_stream_if #(.PW(8), .CNT_W(5), .THRESHOLD_BITS(5)) b16 ();

    bnn_neuron_stream #(.PW(8), .MAX_INPUTS(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    bnn_neuron_stream #(.PW(8), .MAX_INPUTS(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumers: a result is taken on a negedge where valid&&ready.
    always @(negedge clk) begin
        if (!rst && b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                chk("spurious_result32", q32.size(), 1);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("count32", b32.out_count, e.cnt);
                chk("act32", b32.out_act, e.act);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) begin
                chk("spurious_result16", q16.size(), 1);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("count16", b16.out_count, e.cnt);
                chk("act16", b16.out_act, e.act);
            end
        end
    end

    task automatic expect32(input int cnt, input int thr);
        exp_t e;
        e.cnt = cnt;
        e.act = (cnt >= thr);
        q32.push_back(e);
    endtask

    task automatic expect16(input int cnt, input int thr);
        exp_t e;
        e.cnt = cnt;
        e.act = (cnt >= thr);
        q16.push_back(e);
    endtask

    // Drive one beat, hold it until accepted; returns 1 time unit after the
    // accepting edge. sel=0 -> 32-input DUT, sel=1 -> 16-input DUT.
    task automatic beat(input bit sel, input logic [7:0] w, input logic [7:0] x,
                        input logic [7:0] k, input bit last, input int thr);
        bit ok;
        ok = 1'b0;
        if (!sel) begin
            b32.in_valid = 1'b1; b32.in_w = w; b32.in_x = x; b32.in_keep = k;
            b32.in_last = last; b32.in_threshold = 6'(thr);
        end else begin
            b16.in_valid = 1'b1; b16.in_w = w; b16.in_x = x; b16.in_keep = k;
            b16.in_last = last; b16.in_threshold = 5'(thr);
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? b16.in_ready : b32.in_ready;
            @(posedge clk);
            #1;
        end
        chk("beat_accept_timeout", ok, 1);
        if (!sel) b32.in_valid = 1'b0;
        else      b16.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 100 && !empty; i++) begin
            @(posedge clk);
            #1;
            empty = (q32.size() == 0) && (q16.size() == 0);
        end
        chk("drain_timeout", empty, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        b32.in_valid = 1'b0; b32.in_w = '0; b32.in_x = '0; b32.in_keep = '0;
        b32.in_last = 1'b0; b32.in_threshold = '0; b32.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.in_w = '0; b16.in_x = '0; b16.in_keep = '0;
        b16.in_last = 1'b0; b16.in_threshold = '0; b16.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", b32.out_valid, 0);
        chk("rst_out_count", b32.out_count, 0);
        chk("rst_out_act", b32.out_act, 0);
        chk("rst_in_ready", b32.in_ready, 1);
        chk("rst_out_valid16", b16.out_valid, 0);

        // Single beat: 4 matches, thr 4; latency counted in edges incl. accept
        expect32(4, 4);
        beat(0, 8'hFF, 8'hF0, 8'hFF, 1, 4);
        lat = 1;
        while (!b32.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 3);
        drain();

        // Four full-match beats: 32 matches vs thr 33, then thr 32
        expect32(32, 33);
        for (int i = 0; i < 4; i++) beat(0, 8'hA5, 8'hA5, 8'hFF, i == 3, 33);
        expect32(32, 32);
        for (int i = 0; i < 4; i++) beat(0, 8'hA5, 8'hA5, 8'hFF, i == 3, 32);
        // Threshold above MAX_INPUTS never fires
        expect32(32, 63);
        for (int i = 0; i < 4; i++) beat(0, 8'hFF, 8'hFF, 8'hFF, i == 3, 63);
        // Partial lanes
        expect32(4, 5);
        beat(0, 8'h3C, 8'h3C, 8'h0F, 1, 5);
        // keep=0 contributes nothing; thr 0 always fires
        expect32(0, 0);
        beat(0, 8'hFF, 8'hFF, 8'h00, 1, 0);
        drain();

        // Backpressure: three 2-beat vectors, result held for 6 cycles
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        expect32(12, 10);
        expect32(1, 1);
        expect32(4, 7);
        fork
            begin
                beat(0, 8'hFF, 8'hFF, 8'hFF, 0, 0);
                beat(0, 8'h0F, 8'h00, 8'hFF, 1, 10);
                beat(0, 8'h00, 8'h00, 8'h01, 0, 0);
                beat(0, 8'hAA, 8'h55, 8'hFF, 1, 1);
                beat(0, 8'hFF, 8'h00, 8'hFF, 0, 0);
                beat(0, 8'hC3, 8'hC3, 8'h3C, 1, 7);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    seen = b32.out_valid;
                end
                chk("stall_first_valid", seen, 1);
                repeat (6) begin
                    @(negedge clk);
                    chk("stall_in_ready", b32.in_ready, 0);
                    chk("stall_out_valid", b32.out_valid, 1);
                    chk("stall_count", b32.out_count, 12);
                    chk("stall_act", b32.out_act, 1);
                end
                @(posedge clk);
                #1;
                b32.out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-vector discards the partial sum
        beat(0, 8'hFF, 8'hFF, 8'hFF, 0, 0);
        beat(0, 8'hFF, 8'hFF, 8'hFF, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", b32.out_valid, 0);
        chk("midrst_out_count", b32.out_count, 0);
        chk("midrst_out_act", b32.out_act, 0);
        chk("midrst_in_ready", b32.in_ready, 1);
        expect32(3, 2);
        beat(0, 8'h07, 8'h07, 8'h07, 1, 2);
        drain();

        // Saturation on the 16-input instance: 40 matches clamp to 16
        expect16(16, 16);
        for (int i = 0; i < 5; i++) beat(1, 8'hFF, 8'hFF, 8'hFF, i == 4, 16);
        drain();

        // Throughput: single-beat vectors every cycle
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    expect32($countones(i[7:0]), 2);
                    beat(0, 8'(i), 8'hFF, 8'hFF, 1, 2);
                end
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    seen = b32.out_valid;
                end
                chk("tput_first_valid", seen, 1);
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    chk("tput_continuous", b32.out_valid, 1);
                end
                @(negedge clk);
                chk("tput_end", b32.out_valid, 0);
            end
        join
        drain();

        chk("q32_empty", q32.size(), 0);
        chk("q16_empty", q16.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
